stopwatch_bcd: RTL and testbench
================================

// Module: stopwatch_bcd
//
// PURPOSE
//   Stopwatch core driven by the 100 Hz hundrethSec strobe from the clock divider (clkdivComb + divcnt reg).
//   Keeps an MM:SS.hh BCD count with start/stop/clear control.
//   Feeds the seven-segment display mux that follows it.
//
// PARAMETERS
//   MIN_MAX   59   highest minutes value; MIN_MAX:59.99 + 1 tick wraps to 00:00.00 (legal range 0..99)
//
// PORTS
//   clk          in   1  system clock (50 MHz), same clock as the divider
//   rst_n        in   1  asynchronous active-low reset
//   hundrethSec  in   1  one-clk strobe every 500000 clks (divcnt==0x7A11F)
//   start_stop   in   1  debounced, synchronized button level; rising edge acts
//   clr          in   1  debounced, synchronized button level; rising edge acts
//   lap          in   1  (LAP_EN only) debounced, synchronized level; rising edge acts
//   hund_o       out  4  BCD hundredths ones digit
//   hund_t       out  4  BCD hundredths tens digit
//   sec_o        out  4  BCD seconds ones digit
//   sec_t        out  4  BCD seconds tens digit (0..5)
//   min_o        out  4  BCD minutes ones digit
//   min_t        out  4  BCD minutes tens digit
//   running      out  1  high while state==RUN
//   rollover     out  1  one-clk pulse when count wraps MIN_MAX:59.99 -> 00:00.00
//
// BEHAVIOUR
//   - Reset (async, rst_n=0): all digits 0, state IDLE, running 0, rollover 0.
//     Edge-detect flops reset to 1, so a button held through reset release is not a press.
//   - Edge detect: press = level & ~prev_level. Holding a level high yields exactly one press.
//   - FSM states and transitions:
//       IDLE  -start_stop-> RUN
//       RUN   -start_stop-> PAUSE
//       PAUSE -start_stop-> RUN
//       any state -clr-> IDLE, all digits zeroed
//   - Simultaneous events: clr beats start_stop in the same clk.
//   - Counting: count advances only on a clk where (current state==RUN && hundrethSec).
//     A tick coinciding with the press that leaves IDLE/PAUSE is not counted.
//     A tick coinciding with the press that enters PAUSE is counted.
//   - Latency: digits are registered and update the clk after the qualifying tick.
//   - BCD cascade on each counted tick:
//       hund_o 9->0 carries to hund_t
//       hund_t 9->0 carries to sec_o
//       sec_o 9->0 carries to sec_t
//       sec_t 5->0 carries to min_o
//       min_o 9->0 carries to min_t
//   - Wrap: MIN_MAX:59.99 + tick -> 00:00.00 and rollover=1 for exactly that clk; state stays RUN.
//   - Digits never hold a non-BCD value; no count outside 00:00.00..MIN_MAX:59.99.
//   - Reset mid-count: immediate async return to the reset values above, regardless of state.
//
// CONFIGURATION
//   STOPWATCH_LAP_EN defined:
//     - lap port present; outputs come from a display register.
//     - lap press in RUN toggles hold. While held, outputs freeze but the internal count keeps running.
//     - Releasing hold shows the live count on the next clk.
//     - lap in IDLE/PAUSE is ignored. clr or reset clears hold.
//     - running and rollover always reflect live state, even while held.
//   STOPWATCH_LAP_EN undefined:
//     - No lap port, no display register; digit outputs are the live count registers.
//
// TESTING
//   1. Reset, start_stop press, 100 hundrethSec pulses -> 00:01.00, running=1, rollover never 1.
//   2. RUN, drive 360000 ticks (MIN_MAX=59) -> 00:00.00 after last tick, rollover high exactly 1 clk.
//   3. 37 ticks, press start_stop, 10 more ticks -> 00:00.37, running=0;
//      press again, 5 ticks -> 00:00.42.
//   4. In RUN at 00:12.34, clr and start_stop rise in the same clk -> IDLE, all digits 0, running=0.
//   5. start_stop held high 20 clks from IDLE -> one transition to RUN only;
//      same press coincident with a tick -> count stays 00:00.00.
//   6. STOPWATCH_LAP_EN: lap at 00:00.50, 30 ticks -> outputs 00:00.50;
//      lap again -> outputs 00:00.80 next clk.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// MM:SS.hh BCD stopwatch core with start/stop/clear control.
// Optional lap-hold display register when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd #(
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hundrethSec,
    input  logic       start_stop,
    input  logic       clr,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
`endif
    output logic [3:0] hund_o,
    output logic [3:0] hund_t,
    output logic [3:0] sec_o,
    output logic [3:0] sec_t,
    output logic [3:0] min_o,
    output logic [3:0] min_t,
    output logic       running,
    output logic       rollover
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] MAX_T = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX_O = 4'(MIN_MAX % 10);
    // per-digit wrap limits, index 0 = hundredths ones
    localparam logic [5:0][3:0] LIM = {4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    state_t           state_q, state_d;
    logic [5:0][3:0]  cnt_q, cnt_d;
    logic             ss_q, clr_q;
    logic             ss_press, clr_press;
    logic             tick_en, at_max, wrap, carry;

    assign ss_press  = start_stop & ~ss_q;
    assign clr_press = clr & ~clr_q;
    assign tick_en   = (state_q == RUN) && hundrethSec;
    assign at_max    = (cnt_q[5] == MAX_T) && (cnt_q[4] == MAX_O)
                    && (cnt_q[3] == 4'd5) && (cnt_q[2] == 4'd9)
                    && (cnt_q[1] == 4'd9) && (cnt_q[0] == 4'd9);

    // held-through-reset buttons must not register as presses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q  <= 1'b1;
            clr_q <= 1'b1;
        end else begin
            ss_q  <= start_stop;
            clr_q <= clr;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_press) begin
            state_d = IDLE;
        end else if (ss_press) begin
            unique case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        carry = 1'b1;
        if (clr_press) begin
            cnt_d = '0;
        end else if (tick_en) begin
            if (at_max) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                for (int i = 0; i < 6; i++) begin
                    if (carry) begin
                        if (cnt_q[i] == LIM[i]) begin
                            cnt_d[i] = 4'd0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                            carry    = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rollover <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rollover <= wrap;
        end
    end

    assign running = (state_q == RUN);

`ifdef STOPWATCH_LAP_EN
    logic            lap_q, lap_press;
    logic            hold_q, hold_d;
    logic [5:0][3:0] disp_q;

    assign lap_press = lap & ~lap_q;

    always_comb begin
        hold_d = hold_q;
        if (clr_press) begin
            hold_d = 1'b0;
        end else if (lap_press && state_q == RUN) begin
            hold_d = ~hold_q;
        end
    end

    // display tracks the live count unless a lap hold is active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q  <= 1'b1;
            hold_q <= 1'b0;
            disp_q <= '0;
        end else begin
            lap_q  <= lap;
            hold_q <= hold_d;
            if (!hold_d) begin
                disp_q <= cnt_d;
            end
        end
    end

    assign {min_t, min_o, sec_t, sec_o, hund_t, hund_o} = disp_q;
`else
    assign {min_t, min_o, sec_t, sec_o, hund_t, hund_o} = cnt_q;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed self-checking bench for stopwatch_bcd.
// MIN_MAX is reduced to 1 so the wrap case stays short.
module tb_stopwatch_bcd;

    logic       clk;
    logic       rst_n;
    logic       hundrethSec;
    logic       start_stop;
    logic       clr;
    logic       lap;
    logic [3:0] hund_o, hund_t, sec_o, sec_t, min_o, min_t;
    logic       running;
    logic       rollover;
    logic [23:0] digits;

    int n_chk;
    int n_fail;
    int ro_cnt;

    assign digits = {min_t, min_o, sec_t, sec_o, hund_t, hund_o};

    stopwatch_bcd #(.MIN_MAX(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hundrethSec (hundrethSec),
        .start_stop  (start_stop),
        .clr         (clr),
`ifdef STOPWATCH_LAP_EN
        .lap         (lap),
`endif
        .hund_o      (hund_o),
        .hund_t      (hund_t),
        .sec_o       (sec_o),
        .sec_t       (sec_t),
        .min_o       (min_o),
        .min_t       (min_t),
        .running     (running),
        .rollover    (rollover)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rollover) ro_cnt++;
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            hundrethSec = 1'b1;
            step(1);
            hundrethSec = 1'b0;
        end
    endtask

    task automatic press_ss();
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
        step(1);
    endtask

    task automatic press_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(1);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        ro_cnt = 0;
        rst_n = 1'b0;
        hundrethSec = 1'b0;
        start_stop = 1'b1;
        clr = 1'b0;
        lap = 1'b0;
        #1;
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_rollover", 32'(rollover), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("held_through_reset", 32'(running), 32'h0);
        start_stop = 1'b0;
        step(1);

        press_ss();
        check("t1_running", 32'(running), 32'h1);
        tick(100);
        check("t1_digits", 32'(digits), 32'h000100);
        check("t1_no_rollover", 32'(ro_cnt), 32'h0);

        tick(11899);
        check("t2_max", 32'(digits), 32'h015999);
        check("t2_ro_before", 32'(ro_cnt), 32'h0);
        tick(1);
        check("t2_wrap_digits", 32'(digits), 32'h0);
        check("t2_wrap_ro", 32'(rollover), 32'h1);
        check("t2_running", 32'(running), 32'h1);
        step(1);
        check("t2_ro_pulse", 32'(ro_cnt), 32'h1);
        tick(1);
        check("t2_after_wrap", 32'(digits), 32'h000001);

        press_clr();
        check("clr_digits", 32'(digits), 32'h0);
        check("clr_running", 32'(running), 32'h0);

        press_ss();
        tick(37);
        check("t3_37", 32'(digits), 32'h000037);
        press_ss();
        tick(10);
        check("t3_paused", 32'(digits), 32'h000037);
        check("t3_running", 32'(running), 32'h0);
        press_ss();
        tick(5);
        check("t3_42", 32'(digits), 32'h000042);

        start_stop = 1'b1;
        hundrethSec = 1'b1;
        step(1);
        start_stop = 1'b0;
        hundrethSec = 1'b0;
        check("pause_tick_counted", 32'(digits), 32'h000043);
        check("pause_tick_state", 32'(running), 32'h0);
        step(1);
        start_stop = 1'b1;
        hundrethSec = 1'b1;
        step(1);
        start_stop = 1'b0;
        hundrethSec = 1'b0;
        check("resume_tick_skipped", 32'(digits), 32'h000043);
        check("resume_state", 32'(running), 32'h1);
        step(1);

        press_clr();
        press_ss();
        tick(1234);
        check("t4_1234", 32'(digits), 32'h001234);
        clr = 1'b1;
        start_stop = 1'b1;
        step(1);
        check("t4_digits", 32'(digits), 32'h0);
        check("t4_running", 32'(running), 32'h0);
        clr = 1'b0;
        start_stop = 1'b0;
        step(2);
        check("t4_idle_hold", 32'(running), 32'h0);

        start_stop = 1'b1;
        hundrethSec = 1'b1;
        step(1);
        hundrethSec = 1'b0;
        check("t5_tick_skipped", 32'(digits), 32'h0);
        check("t5_run", 32'(running), 32'h1);
        step(19);
        check("t5_single_press", 32'(running), 32'h1);
        start_stop = 1'b0;
        step(1);
        tick(3);
        check("t5_count", 32'(digits), 32'h000003);

        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_digits", 32'(digits), 32'h0);
        check("midrst_running", 32'(running), 32'h0);
        step(1);
        rst_n = 1'b1;
        step(2);

`ifdef STOPWATCH_LAP_EN
        press_ss();
        tick(50);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        step(1);
        tick(30);
        check("t6_held", 32'(digits), 32'h000050);
        check("t6_running", 32'(running), 32'h1);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check("t6_release", 32'(digits), 32'h000080);
        step(1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
